array_ram_clr: RTL

ARRAY_RAM_CLR -- requirements
Module: array_ram_clr

---
 rtl/array_ram_clr.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/array_ram_clr.sv
// array_ram_clr: single-clock RAM with byte-enable writes and a sequenced
// full-memory clear that also runs automatically after reset.
// Reads take 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
// Optional feature macro: ARRAY_RAM_BYPASS_EN. When it is defined, a read
// to the address being written in the same cycle returns the merged word.
// When it is not defined, that read returns the old stored word.
module array_ram_clr #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int ADDR    = 4,
  parameter int OUT_REG = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_req,
  output logic               clr_busy,
  input  logic               write_en,
  input  logic [ADDR-1:0]    write_addr,
  input  logic [WIDTH-1:0]   write_data,
  input  logic [WIDTH/8-1:0] write_be,
  input  logic               read_en,
  input  logic [ADDR-1:0]    read_addr,
  output logic [WIDTH-1:0]   read_data,
  output logic               read_valid
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR-1:0] LAST_CNT = ADDR'(DEPTH - 1);
  localparam logic [ADDR:0]   DEPTH_X  = (ADDR + 1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             in_idle;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_ok;
  logic             rd_fire;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_mem;

  logic             rd_valid1_q;
  logic [WIDTH-1:0] rd_data1_q;

  // Accesses are honoured only in IDLE. An out-of-range address is never used to index the array.
  assign in_idle     = (state_q == IDLE);
  assign wr_in_range = ({1'b0, write_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, read_addr} < DEPTH_X);
  assign wr_ok       = in_idle && write_en && wr_in_range;
  assign rd_fire     = in_idle && read_en;
  assign clr_busy    = (state_q == CLEAR);

  // State and clear counter. Reset parks the FSM in CLEAR at word 0, so a full clear follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. A clear request is ignored while a clear is already running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory array, which has no reset. The clear sequence zeroes one word per cycle. Outside a clear, byte-enabled writes update the array.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (write_be[k]) begin
          mem[write_addr][8*k +: 8] <= write_data[8*k +: 8];
        end
      end
    end
  end

  // Stored word at the read address. An out-of-range read returns zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[read_addr];
    end
  end

  // Read-during-write selection for a same-cycle access to the same address.
  always_comb begin
    rd_mem = rd_word;
`ifdef ARRAY_RAM_BYPASS_EN
    if (wr_ok && (write_addr == read_addr)) begin
      for (int k = 0; k < NB; k++) begin
        if (write_be[k]) begin
          rd_mem[8*k +: 8] = write_data[8*k +: 8];
        end
      end
    end
`endif
  end

  // First read stage. The data register updates only on a read, so the output holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid1_q <= 1'b0;
      rd_data1_q  <= '0;
    end else begin
      rd_valid1_q <= rd_fire;
      if (rd_fire) begin
        rd_data1_q <= rd_mem;
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : g_lat1
      assign read_data  = rd_data1_q;
      assign read_valid = rd_valid1_q;
    end else begin : g_lat2
      logic             rd_valid2_q;
      logic [WIDTH-1:0] rd_data2_q;

      // Optional output register. Reset flushes it, so an in-flight read never appears after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid2_q <= 1'b0;
          rd_data2_q  <= '0;
        end else begin
          rd_valid2_q <= rd_valid1_q;
          if (rd_valid1_q) begin
            rd_data2_q <= rd_data1_q;
          end
        end
      end

      assign read_data  = rd_data2_q;
      assign read_valid = rd_valid2_q;
    end
  endgenerate

endmodule
